// File: rtl/booth_mult32.sv
// Iterative radix-2 Booth signed multiplier: one add/sub-and-shift step per clock,
// WIDTH steps per product, low WIDTH bits returned with a signed-overflow flag.
module booth_mult32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  localparam int HW = WIDTH + 1;
  localparam int PW = 2 * WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: a start is accepted on any edge where ctrl_MULT=1 and the unit is
  // in IDLE or DONE; data_resultRDY is a one-cycle valid with no ready back-pressure.

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [HW-1:0]    r_m;
  logic [PW-1:0]    r_p;
  logic [WIDTH-1:0] r_result;
  logic             r_exc;

  logic             w_start;
  logic             w_last;
  logic             w_busy;
  logic             w_rdy;
  logic [HW-1:0]    w_h;
  logic [WIDTH-1:0] w_l;
  logic             w_q;
  logic [HW-1:0]    w_h_sum;
  logic [PW-1:0]    w_p_next;
  logic             w_exc_next;

  assign w_start = ctrl_MULT && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last  = (r_state == S_BUSY) && (r_cnt == CNT_W'(WIDTH - 1));

  // Product register layout: {H[WIDTH:0], L[WIDTH-1:0], q}
  assign w_h = r_p[PW-1:WIDTH+1];
  assign w_l = r_p[WIDTH:1];
  assign w_q = r_p[0];

  always_comb begin
    w_h_sum = w_h;
    case ({w_l[0], w_q})
      2'b01:   w_h_sum = w_h + r_m;
      2'b10:   w_h_sum = w_h - r_m;
      default: w_h_sum = w_h;
    endcase
  end

  // Arithmetic right shift of {H,L,q}, sign-filled from the updated H
  assign w_p_next   = {w_h_sum[HW-1], w_h_sum, w_l};
  assign w_exc_next = (w_p_next[2*WIDTH:WIDTH+1] != {WIDTH{w_p_next[WIDTH]}});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (ctrl_MULT) w_state_next = S_BUSY;
      S_BUSY:  if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = ctrl_MULT ? S_BUSY : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_rdy  = 1'b0;
    case (r_state)
      S_BUSY:  w_busy = 1'b1;
      S_DONE:  w_rdy  = 1'b1;
      default: begin
        w_busy = 1'b0;
        w_rdy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_m      <= '0;
      r_p      <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else if (w_start) begin
      r_m   <= {data_operandA[WIDTH-1], data_operandA};
      r_p   <= {{HW{1'b0}}, data_operandB, 1'b0};
      r_cnt <= '0;
    end else if (r_state == S_BUSY) begin
      r_p   <= w_p_next;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_result <= w_p_next[WIDTH:1];
        r_exc    <= w_exc_next;
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = w_rdy;
  assign busy           = w_busy;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_booth_mult32.sv
// Directed bench for booth_mult32: latency, products, overflow flag, ignored
// restarts, back-to-back starts and asynchronous reset mid-operation.
module tb_booth_mult32;

  logic        clock;
  logic        reset_n;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
  logic [1:0]  o_dbg_state;

  int errors = 0;
  int checks = 0;
  int rdy_seen = 0;
  int lat;
  int snap;

  booth_mult32 #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .o_dbg_state    (o_dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (data_resultRDY === 1'b1) rdy_seen++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(output int l);
    l = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic exp_e);
    @(negedge clock);
    start(a, b);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_rdy(lat);
    check({tag, "_lat"}, 64'(lat), 64'd32);
    check({tag, "_res"}, 64'(data_result), 64'(exp_r));
    check({tag, "_exc"}, 64'(data_exception), 64'(exp_e));
    @(negedge clock);
    check({tag, "_rdy_low"}, 64'(data_resultRDY), 64'd0);
  endtask

  initial begin
    reset_n       = 1'b0;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    check("rst_res", 64'(data_result), 64'd0);
    check("rst_exc", 64'(data_exception), 64'd0);
    check("rst_rdy", 64'(data_resultRDY), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_state", 64'(o_dbg_state), 64'd0);
    reset_n = 1'b1;

    run_op("m7x-3", 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    repeat (5) @(negedge clock);
    check("hold_res", 64'(data_result), 64'hFFFF_FFEB);
    check("hold_busy", 64'(busy), 64'd0);

    run_op("minx-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op("minx1", 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0);
    run_op("2p16sq", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    run_op("minxmin", 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);
    run_op("m-1x-1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("m12345x-678", 32'd12345, -32'sd678, -32'sd8369910, 1'b0);

    // Restart attempt while busy must be ignored
    @(negedge clock);
    snap = rdy_seen;
    start(32'd5, 32'd5);
    repeat (9) @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd9;
    data_operandB = 32'd9;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    check("ign_busy", 64'(busy), 64'd1);
    wait_rdy(lat);
    check("ign_lat", 64'(lat), 64'd22);
    check("ign_res", 64'(data_result), 64'd25);
    check("ign_exc", 64'(data_exception), 64'd0);

    // Back-to-back start in the DONE cycle
    start(32'd3, 32'd4);
    check("b2b_rdy_low", 64'(data_resultRDY), 64'd0);
    check("b2b_busy", 64'(busy), 64'd1);
    wait_rdy(lat);
    check("b2b_lat", 64'(lat + 1), 64'd33);
    check("b2b_res", 64'(data_result), 64'd12);
    repeat (3) @(negedge clock);
    #1;
    check("b2b_rdy_count", 64'(rdy_seen - snap), 64'd2);

    // Asynchronous reset in the middle of 6x6
    @(negedge clock);
    start(32'd6, 32'd6);
    repeat (14) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("arst_res", 64'(data_result), 64'd0);
    check("arst_exc", 64'(data_exception), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_rdy", 64'(data_resultRDY), 64'd0);
    check("arst_state", 64'(o_dbg_state), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    snap = rdy_seen;
    repeat (40) @(negedge clock);
    #1;
    check("arst_no_rdy", 64'(rdy_seen - snap), 64'd0);
    check("arst_idle", 64'(busy), 64'd0);

    run_op("m2x-2", 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
